fetch_frontend: RTL

//  Parametrised front end: PC generation, I-mem request FSM and N-deep fetch queue in one block.

---
 rtl/fe_pkg.sv | 27 ++
 rtl/fe_fifo.sv | 63 ++++++
 rtl/fetch_frontend.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/fe_pkg.sv
// Shared types for the fetch front end.
//   fe_state_t    : I-mem request FSM states
//   fetch_entry_t : fetch queue entry at the default 32-bit width (default
//                   payload type of fe_fifo; the top builds its own entry
//                   struct at its WIDTH with the same field layout)
//   sat_inc       : saturating 32-bit increment used by the statistics counters
package fe_pkg;

    localparam int FE_DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fe_state_t;

    typedef struct packed {
        logic [FE_DEFAULT_WIDTH-1:0] instr;
        logic [FE_DEFAULT_WIDTH-1:0] pc;
        logic                        pred_taken;
    } fetch_entry_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

endpackage

// File: rtl/fe_fifo.sv
// Circular-buffer FIFO with synchronous clear.
//   clk, rst   : clock, synchronous active-high reset
//   enq        : push enq_data (ignored when full)
//   deq        : pop head (ignored when empty)
//   clear      : empty the queue this edge; wins over enq/deq
//   head       : entry at the read pointer
//   empty/full : occupancy flags
//   count      : occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module fe_fifo
    import fe_pkg::*;
#(
    parameter type T     = fetch_entry_t,
    parameter int  DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enq,
    input  T                         enq_data,
    input  logic                     deq,
    input  logic                     clear,
    output T                         head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    T              mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_enq;
    logic          do_deq;

    assign empty  = (count == '0);
    assign full   = (count == FULL_CNT);
    assign do_deq = deq && !empty;
    assign do_enq = enq && !full;
    assign head   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_enq) wr_ptr <= wr_ptr + AW'(1);
            if (do_deq) rd_ptr <= rd_ptr + AW'(1);
            case ({do_enq, do_deq})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage has no reset; contents are only observable behind count.
    always_ff @(posedge clk) begin
        if (do_enq && !clear && !rst) mem[wr_ptr] <= enq_data;
    end

endmodule

// File: rtl/fetch_frontend.sv
// Fetch front end: PC generation, single-outstanding I-mem request FSM and
// an IQ_DEPTH-entry fetch queue feeding decode.
//   clk, rst            : clock, synchronous active-high reset
//   i_mem_*             : instruction memory port (read held until resp)
//   pred_taken/target   : branch prediction for the word returned this cycle
//   flush_valid/pc      : redirect from the ROB; clears the queue
//   iq_*                : fetch queue head, pop, and status
// Optional build macro FETCH_STATS_EN adds stat_fetched, stat_flushes and
// stat_dropped (32-bit saturating counters).
module fetch_frontend
    import fe_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter int               IQ_DEPTH = 8,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'('h60)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_mem_resp,
    input  logic [WIDTH-1:0]            i_mem_rdata,
    output logic                        i_mem_read,
    output logic [WIDTH-1:0]            i_mem_address,
    output logic [WIDTH/8-1:0]          i_mem_byte_enable,
    input  logic                        pred_taken,
    input  logic [WIDTH-1:0]            pred_target,
    input  logic                        flush_valid,
    input  logic [WIDTH-1:0]            flush_pc,
    input  logic                        iq_deq,
    output logic                        iq_valid,
    output logic [WIDTH-1:0]            iq_instr,
    output logic [WIDTH-1:0]            iq_pc,
    output logic                        iq_pred_taken,
    output logic                        iq_full,
    output logic [$clog2(IQ_DEPTH):0]   iq_count
`ifdef FETCH_STATS_EN
   ,output logic [31:0]                 stat_fetched,
    output logic [31:0]                 stat_flushes,
    output logic [31:0]                 stat_dropped
`endif
);
    localparam int CW = $clog2(IQ_DEPTH) + 1;

    typedef struct packed {
        logic [WIDTH-1:0] instr;
        logic [WIDTH-1:0] pc;
        logic             pred_taken;
    } entry_t;

    fe_state_t        state;
    logic [WIDTH-1:0] fetch_pc;
    logic [WIDTH-1:0] saved_pc;
    logic [WIDTH-1:0] next_pc;
    logic             reserved;
    logic             can_issue;
    logic             enq;
    logic             dropped;
    logic             iq_empty;
    entry_t           enq_entry;
    entry_t           head;

    assign i_mem_byte_enable = '1;

    // An outstanding request owns a queue slot until its response returns,
    // so the queue can never overflow on enqueue.
    assign reserved  = (state != IDLE);
    assign can_issue = (iq_count + CW'(reserved)) < CW'(IQ_DEPTH);

    assign next_pc   = pred_taken ? pred_target : fetch_pc + WIDTH'(4);
    assign enq       = (state == WAIT) && i_mem_resp && !flush_valid;
    assign dropped   = i_mem_resp && ((state == DRAIN) || ((state == WAIT) && flush_valid));
    assign enq_entry = '{instr: i_mem_rdata, pc: fetch_pc, pred_taken: pred_taken};

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            fetch_pc      <= RESET_PC;
            saved_pc      <= '0;
            i_mem_read    <= 1'b0;
            i_mem_address <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    // A response arriving here is a leftover from before a
                    // reset and is deliberately ignored.
                    if (flush_valid) begin
                        fetch_pc <= flush_pc;
                    end else if (can_issue) begin
                        i_mem_read    <= 1'b1;
                        i_mem_address <= fetch_pc;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    if (i_mem_resp) begin
                        i_mem_read <= 1'b0;
                        state      <= IDLE;
                        fetch_pc   <= flush_valid ? flush_pc : next_pc;
                    end else if (flush_valid) begin
                        // Request cannot be withdrawn: wait out its response.
                        saved_pc <= flush_pc;
                        state    <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (i_mem_resp) begin
                        i_mem_read <= 1'b0;
                        state      <= IDLE;
                        fetch_pc   <= flush_valid ? flush_pc : saved_pc;
                    end else if (flush_valid) begin
                        saved_pc <= flush_pc;
                    end
                end
                default: begin
                    state      <= IDLE;
                    i_mem_read <= 1'b0;
                end
            endcase
        end
    end

    fe_fifo #(
        .T     (entry_t),
        .DEPTH (IQ_DEPTH)
    ) u_iq (
        .clk      (clk),
        .rst      (rst),
        .enq      (enq),
        .enq_data (enq_entry),
        .deq      (iq_deq),
        .clear    (flush_valid),
        .head     (head),
        .empty    (iq_empty),
        .full     (iq_full),
        .count    (iq_count)
    );

    assign iq_valid      = !iq_empty;
    assign iq_instr      = head.instr;
    assign iq_pc         = head.pc;
    assign iq_pred_taken = head.pred_taken;

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_fetched <= '0;
            stat_flushes <= '0;
            stat_dropped <= '0;
        end else begin
            stat_fetched <= sat_inc(stat_fetched, enq);
            stat_flushes <= sat_inc(stat_flushes, flush_valid);
            stat_dropped <= sat_inc(stat_dropped, dropped);
        end
    end
`else
    logic unused_stats;
    assign unused_stats = dropped;
`endif

endmodule
